// File: rtl/elevator_pkg.sv
// elevator_pkg: shared widths, direction encoding and dispatcher states
package elevator_pkg;
  localparam int FLOOR_W = 3;
  localparam int MAX_FLOORS = 8;
  typedef enum logic [1:0] {DIR_IDLE = 2'b00, DIR_UP = 2'b01, DIR_DN = 2'b10} dir_t;
  typedef enum logic [1:0] {S_IDLE, S_STEP, S_EVAL, S_DOOR} state_t;
endpackage

// File: rtl/elevator_dispatcher_if.sv
// elevator_dispatcher_if: request inputs and motion-unit step handshake
interface elevator_dispatcher_if;
  import elevator_pkg::*;
  logic               car_req_valid;
  logic [FLOOR_W-1:0] car_req_floor;
  logic               hall_req_valid;
  logic [FLOOR_W-1:0] hall_req_floor;
  logic               step_req;
  logic               step_up;
  logic               step_ack;
  modport master (output car_req_valid, car_req_floor, hall_req_valid, hall_req_floor, step_ack,
                  input step_req, step_up);
  modport slave (input car_req_valid, car_req_floor, hall_req_valid, hall_req_floor, step_ack,
                 output step_req, step_up);
endinterface

// File: rtl/elevator_scan_pick.sv
// elevator_scan_pick: flags pending floors at, above and below the car
module elevator_scan_pick
  import elevator_pkg::*;
(
  input  logic [MAX_FLOORS-1:0] i_pending,
  input  logic [FLOOR_W-1:0]    i_cur_floor,
  output logic                  o_any_above,
  output logic                  o_any_below,
  output logic                  o_hit_cur
);
  logic [MAX_FLOORS-1:0] w_cur_bit;
  logic [MAX_FLOORS-1:0] w_below_mask;
  assign w_cur_bit    = 8'd1 << i_cur_floor;
  assign w_below_mask = w_cur_bit - 8'd1;
  assign o_hit_cur    = i_pending[i_cur_floor];
  assign o_any_below  = |(i_pending & w_below_mask);
  assign o_any_above  = |(i_pending & ~w_below_mask & ~w_cur_bit);
endmodule

// File: rtl/elevator_dispatcher.sv
// elevator_dispatcher: single-car scan dispatcher with door dwell and step handshake
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = 8,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  elevator_dispatcher_if.slave  bus,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic [1:0]            dir,
  output logic                  door_open,
  output logic [MAX_FLOORS-1:0] pending
);
  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  state_t                r_state, w_state;
  dir_t                  r_dir, w_dir;
  logic [FLOOR_W-1:0]    r_cur, w_cur;
  logic [MAX_FLOORS-1:0] r_pending, w_pending;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic [MAX_FLOORS-1:0] w_req, w_cur_bit;
  logic                  w_car_ok, w_hall_ok, w_cur_req;
  logic                  w_above, w_below, w_hit, w_ahead, w_behind;
  elevator_scan_pick u_scan (
    .i_pending   (r_pending),
    .i_cur_floor (r_cur),
    .o_any_above (w_above),
    .o_any_below (w_below),
    .o_hit_cur   (w_hit)
  );
  assign w_car_ok  = bus.car_req_valid && (int'(bus.car_req_floor) < NUM_FLOORS);
  assign w_hall_ok = bus.hall_req_valid && (int'(bus.hall_req_floor) < NUM_FLOORS);
  assign w_req     = (w_car_ok ? 8'd1 << bus.car_req_floor : 8'd0) |
                     (w_hall_ok ? 8'd1 << bus.hall_req_floor : 8'd0);
  assign w_cur_bit = 8'd1 << r_cur;
  assign w_cur_req = |(w_req & w_cur_bit);
  // IDLE behaves like EVAL with no direction, so "ahead" degrades to "above"
  assign w_ahead   = (r_dir == DIR_DN) ? w_below : w_above;
  assign w_behind  = (r_dir == DIR_DN) ? w_above : w_below;
  always_comb begin
    w_state   = r_state;
    w_dir     = r_dir;
    w_cur     = r_cur;
    w_cnt     = r_cnt;
    w_pending = r_pending | ((r_state == S_DOOR) ? w_req & ~w_cur_bit : w_req);
    case (r_state)
      S_IDLE, S_EVAL: begin
        if (w_hit) begin
          w_state   = S_DOOR;
          w_cnt     = '0;
          w_pending = w_pending & ~w_cur_bit;
        end else if (w_ahead) begin
          w_state = S_STEP;
          w_dir   = (r_dir == DIR_DN) ? DIR_DN : DIR_UP;
        end else if (w_behind) begin
          w_state = S_STEP;
          w_dir   = (r_dir == DIR_DN) ? DIR_UP : DIR_DN;
        end else begin
          w_state = S_IDLE;
          w_dir   = DIR_IDLE;
        end
      end
      S_STEP: if (bus.step_ack) begin
        w_cur   = (r_dir == DIR_UP) ? r_cur + 3'd1 : r_cur - 3'd1;
        w_state = S_EVAL;
      end
      S_DOOR: begin
        if (w_cur_req) w_cnt = '0;
        else if (r_cnt == CNT_W'(DWELL_CYCLES - 1)) w_state = S_EVAL;
        else w_cnt = r_cnt + 1'b1;
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dir     <= DIR_IDLE;
      r_cur     <= '0;
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state;
      r_dir     <= w_dir;
      r_cur     <= w_cur;
      r_pending <= w_pending;
      r_cnt     <= w_cnt;
    end
  end
  assign bus.step_req = (r_state == S_STEP);
  assign bus.step_up  = (r_dir == DIR_UP);
  assign door_open    = (r_state == S_DOOR);
  assign cur_floor    = r_cur;
  assign dir          = r_dir;
  assign pending      = r_pending;
endmodule

// File: doc/elevator_dispatcher.md
ELEVATOR_DISPATCHER -- requirements
Module: elevator_dispatcher

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 8, number of served floors (2..8).
REQ-002 SHALL have parameter DWELL_CYCLES, default 4, door-open cycles per stop (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports car_req_valid  input  1 and car_req_floor  input  3  for the in-car button requester.
REQ-006 SHALL have ports hall_req_valid  input  1 and hall_req_floor  input  3  for the hall-call requester.
REQ-007 SHALL have port step_req  output  1  request to the motion unit to move one floor.
REQ-008 SHALL have port step_up  output  1  step direction: 1 up, 0 down; valid while step_req=1.
REQ-009 SHALL have port step_ack  input  1  one-cycle pulse: motion unit finished the requested step.
REQ-010 SHALL have port cur_floor  output  3  floor the car is at.
REQ-011 SHALL have port dir  output  2  travel direction: 00 idle, 01 up, 10 down.
REQ-012 SHALL have port door_open  output  1  door open at cur_floor.
REQ-013 SHALL have port pending  output  8  one bit per floor with an outstanding request; bits >= NUM_FLOORS read 0.

Function
REQ-014 SHALL set pending[f] on the cycle after either valid requester presents floor f < NUM_FLOORS; out-of-range floors are ignored.
REQ-015 SHALL accept car and hall requests in the same cycle; same floor from both sets one bit; a floor already pending is unchanged.
REQ-016 SHALL implement states IDLE, STEP, EVAL, DOOR.
REQ-017 IDLE: priority pending[cur_floor] -> DOOR; else any pending above -> dir=01, STEP; else any below -> dir=10, STEP; else stay, dir=00.
REQ-018 STEP: step_req=1, step_up=(dir==01), held until step_ack; on ack cur_floor +/-1, step_req=0 next cycle, go EVAL.
REQ-019 EVAL (one cycle): pending[cur_floor] -> DOOR; else pending ahead in dir -> STEP; else pending behind -> flip dir, STEP; else dir=00, IDLE.
REQ-020 SHALL clear pending[cur_floor] on the cycle DOOR is entered.
REQ-021 DOOR: door_open=1 exactly DWELL_CYCLES cycles, then EVAL; step_req=0 throughout.
REQ-022 A request for cur_floor arriving during DOOR SHALL restart the dwell count and SHALL NOT set pending.
REQ-023 step_ack outside STEP SHALL be ignored.
REQ-024 cur_floor SHALL never step below 0 or above NUM_FLOORS-1 (guaranteed by REQ-019 scan order).
REQ-025 door_open and step_req SHALL never be 1 in the same cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, cur_floor 0, dir 00, pending 0, door_open 0, step_req 0, dwell counter 0, including mid-STEP or mid-DOOR.

Structure
REQ-027 Package elevator_pkg SHALL hold FLOOR_W=3, the dir encoding and the state enum.
REQ-028 Sub-module elevator_scan_pick SHALL compute any_above, any_below, hit_cur from pending and cur_floor combinationally.

Verification
REQ-029 Reset, hall_req floor 5, ack each step after 3 cycles -> five step_req up, cur_floor 5, door_open 4 cycles, pending 0, IDLE dir 00.
REQ-030 At floor 3 moving up, car_req 6 and hall_req 1 same cycle -> serves 6 first, dir flips to 10, then serves 1.
REQ-031 car_req and hall_req both floor 2 same cycle -> pending=0x04, single DOOR stop at 2.
REQ-032 Request cur_floor on dwell cycle 2 -> door_open high 6 consecutive cycles, pending unchanged.
REQ-033 rst_n low during STEP (floor 4, step_req=1) -> step_req 0 same cycle, cur_floor 0, pending 0.
REQ-034 Spurious step_ack in IDLE and DOOR -> cur_floor unchanged.
